// File: rtl/texture_palette_ram.sv
// Runtime-loadable colour palette with a valid/ready bulk-load port and NUM_RD independent,
// two-stage shaded read channels. Loads and reads may overlap; same-address collisions are write-first.
module texture_palette_ram #(
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned CH_W    = 4,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned SHADE_W = 2
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        load_start,
  input  logic                        load_valid,
  input  logic [3*CH_W-1:0]           load_data,
  output logic                        load_ready,
  output logic                        load_busy,
  output logic                        load_done,
  input  logic [NUM_RD-1:0]           rd_valid_in,
  input  logic [NUM_RD*IDX_W-1:0]     rd_index,
  input  logic [NUM_RD*SHADE_W-1:0]   rd_shade,
  output logic [NUM_RD-1:0]           rd_valid_out,
  output logic [NUM_RD*CH_W-1:0]      red,
  output logic [NUM_RD*CH_W-1:0]      green,
  output logic [NUM_RD*CH_W-1:0]      blue
);

  localparam int unsigned DEPTH  = 2 ** IDX_W;
  localparam int unsigned ENT_W  = 3 * CH_W;
  localparam int unsigned PROD_W = CH_W + SHADE_W + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   addr_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic               wr_en;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  // ready_q is high exactly while in StLoad, so it doubles as the write qualifier.
  assign wr_en      = ready_q & load_valid;
  assign load_ready = ready_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            state_q <= StLoad;
            addr_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          if (load_valid) begin
            addr_q <= addr_q + 1'b1;
            if (&addr_q) begin
              state_q <= StDone;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[addr_q] <= load_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_ch
    logic [IDX_W-1:0]   idx;
    logic [ENT_W-1:0]   s1_col_q;
    logic [SHADE_W-1:0] s1_shade_q;
    logic               s1_valid_q;
    logic [SHADE_W:0]   factor;
    logic [PROD_W-1:0]  prod_r, prod_g, prod_b;
    logic [CH_W-1:0]    r_q, g_q, b_q;
    logic               valid_q;

    assign idx = rd_index[k*IDX_W +: IDX_W];

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        s1_col_q   <= '0;
        s1_shade_q <= '0;
        s1_valid_q <= 1'b0;
      end else begin
        s1_col_q   <= (wr_en && (addr_q == idx)) ? load_data : mem_q[idx];
        s1_shade_q <= rd_shade[k*SHADE_W +: SHADE_W];
        s1_valid_q <= rd_valid_in[k];
      end
    end

    // factor = 2**SHADE_W - shade; product stays below 2**(CH_W+SHADE_W) so the slice is exact.
    assign factor = {1'b1, {SHADE_W{1'b0}}} - {1'b0, s1_shade_q};
    assign prod_r = PROD_W'(s1_col_q[2*CH_W +: CH_W]) * PROD_W'(factor);
    assign prod_g = PROD_W'(s1_col_q[CH_W +: CH_W]) * PROD_W'(factor);
    assign prod_b = PROD_W'(s1_col_q[0 +: CH_W]) * PROD_W'(factor);

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        r_q     <= '0;
        g_q     <= '0;
        b_q     <= '0;
        valid_q <= 1'b0;
      end else begin
        r_q     <= prod_r[SHADE_W +: CH_W];
        g_q     <= prod_g[SHADE_W +: CH_W];
        b_q     <= prod_b[SHADE_W +: CH_W];
        valid_q <= s1_valid_q;
      end
    end

    assign red[k*CH_W +: CH_W]   = r_q;
    assign green[k*CH_W +: CH_W] = g_q;
    assign blue[k*CH_W +: CH_W]  = b_q;
    assign rd_valid_out[k]       = valid_q;
  end

endmodule

// File: doc/texture_palette_ram.md
Name: texture_palette_ram

Overview:
- Runtime-loadable colour palette for the texture pipeline. It replaces fixed, constant-table palettes with one writable store shared by all textures.
- Provides NUM_RD independent read channels, one per texture sampler or render lane. Each channel carries a per-lookup shade factor used for face lighting.
- Contents are bulk-loaded from a valid/ready stream, e.g. from the on-chip memory or the host interface, at scene change.
- Sits between the texture index ROMs and the colour mapper.

Parameters:
- IDX_W, 8, palette index width; DEPTH = 2**IDX_W entries.
- CH_W, 4, bits per colour channel; entry width = 3*CH_W, packed {r,g,b}.
- NUM_RD, 2, number of independent read channels.
- SHADE_W, 2, shade factor width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- load_start  in  1  request a full palette load; sampled only in IDLE.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  3*CH_W  entry {r,g,b} for the current load address.
- load_ready  out  1  high only in LOAD.
- load_busy  out  1  high in LOAD and DONE.
- load_done  out  1  single-cycle pulse after the last entry is written.
- rd_valid_in  in  NUM_RD  per-channel lookup request.
- rd_index  in  NUM_RD*IDX_W  per-channel index; channel k occupies [k*IDX_W +: IDX_W].
- rd_shade  in  NUM_RD*SHADE_W  per-channel shade factor.
- rd_valid_out  out  NUM_RD  per-channel result valid, 2 cycles after rd_valid_in.
- red, green, blue  out  NUM_RD*CH_W each  shaded colour per channel.

Behaviour:
- Storage: DEPTH x 3*CH_W registers.
- Reset, asynchronous, Reset_n=0:
  - all entries cleared to 0; FSM to IDLE; load address to 0.
  - load_ready=0, load_busy=0, load_done=0.
  - all pipeline registers cleared, so rd_valid_out=0 and red/green/blue=0.
- Load FSM, states IDLE, LOAD, DONE:
  - IDLE: load_start=1 -> LOAD, with load address = 0.
  - LOAD: each cycle with load_valid & load_ready, write load_data to entry[addr] and increment addr.
  - LOAD: load_valid gaps stall with no write. load_start is ignored.
  - LOAD: the write at addr==DEPTH-1 moves the FSM to DONE. The address wraps to 0 and is not held.
  - DONE: load_done=1 for exactly one cycle, then IDLE.
  - A load_start asserted in DONE is ignored; it must be re-asserted in IDLE.
- Read pipeline, per channel, fully independent, throughput 1 lookup/cycle/channel:
  - Stage 1 registers: entry[rd_index], rd_shade, rd_valid_in.
  - Stage 2 registers: the shaded colour and valid.
  - Latency is exactly 2 cycles from rd_valid_in to rd_valid_out.
  - Stage registers load every cycle regardless of valid. red/green/blue are only meaningful when rd_valid_out=1.
- Write/read collision is write-first. If stage 1 reads the address being written in the same cycle, it captures load_data, not the old entry. The same applies to several channels reading that address together.
- Reads during LOAD are legal. They return the current mixed old/new contents; no stall.
- Shade arithmetic, per component c (CH_W bits):
  - out = (c * (2**SHADE_W - shade)) >> SHADE_W, truncating.
  - The product is computed at CH_W+SHADE_W+1 bits, with no overflow.
  - shade=0 passes c unchanged. The maximum shade never produces a result greater than c.
- Reset mid-load: the load aborts with no load_done pulse and the contents are cleared. A new load_start is required.

Test Plan:
- Reset -> every output 0. Then read idx 0x00 and 0xFF on both channels with shade 0 -> rd_valid_out at cycle+2, colour 0x000.
- Load test:
  - Stimulus: load_start, then 256 entries with data = {idx[3:0], ~idx[3:0], idx[7:4]}. Insert load_valid gaps every 3rd cycle.
  - Response: load_ready high throughout LOAD, load_done pulses once after entry 255, FSM returns to IDLE.
  - Readback of all indices on ch0, shade 0, matches the written data.
- Shade: entry 0x12 = {F,8,4}, 2 channels:
  - ch0 shade 1 -> {B,6,3}.
  - ch1 shade 3 -> {3,2,1}.
  - Both same cycle, both valid 2 cycles later.
- Collision: during LOAD, write addr 0x40 = 0xABC while ch0 and ch1 both read 0x40 -> both output 0xABC. A read of 0x41 in the same cycle returns its old value.
- Back-to-back streaming: ch0 reads idx 0..15 on consecutive cycles with shade 2 -> 16 consecutive valid outputs, each equal to the entry halved per component, in order.
- Reset mid-load: deassert Reset_n after 100 entries -> no load_done, entries 0..99 read as 0. A load_start issued in DONE is ignored.
